// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding and the width of the latency counter.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_reg.sv
// Generic load-enabled register with asynchronous active-high clear.
// The parent uses it to hold the accepted request.
module data_mem_responder_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       q <= '0;
      else if (load) q <= d;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers load/store requests after a fixed
// latency with a one-cycle acknowledge carrying read data and error status.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               we,
   input  logic [31:0]        addr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [WIDTH/8-1:0] be,
   output logic               ready,
   output logic               ack,
   output logic [WIDTH-1:0]   rdata,
   output logic               err
);

   localparam int BE_W  = WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int REQ_W = 1 + 32 + WIDTH + BE_W;

   typedef struct packed {
      logic             we;
      logic [31:0]      addr;
      logic [WIDTH-1:0] wdata;
      logic [BE_W-1:0]  be;
   } req_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             access;
   logic             accept;
   req_t             cap;
   logic [IDX_W-1:0] idx;
   logic             fault;

   logic [WIDTH-1:0] mem [DEPTH];

   assign accept = (state == IDLE) && req;

   data_mem_responder_reg #(.W(REQ_W)) u_req_reg (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .d    ({we, addr, wdata, be}),
      .q    (cap)
   );

   assign idx   = cap.addr[IDX_W+1:2];
   assign fault = (cap.addr[1:0] != 2'b00) || ({2'b00, cap.addr[31:2]} >= 32'(DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: defaults assigned first keep this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      access    = 1'b0;
      case (state)
         IDLE: if (req) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LATENCY - 1);
         end
         BUSY: if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
         end else begin
            access    = 1'b1;
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign ready = (state == IDLE);
   assign ack   = (state == RESP);

   // NOTE: the array has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (access && cap.we && !fault) begin
         for (int i = 0; i < BE_W; i++) begin
            if (cap.be[i]) mem[idx][8*i +: 8] <= cap.wdata[8*i +: 8];
         end
      end
   end

   // Response data is cleared on leaving RESP so it only carries meaning under ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
         err   <= 1'b0;
      end else if (access) begin
         err   <= fault;
         rdata <= (!cap.we && !fault) ? mem[idx] : '0;
      end else if (state == RESP) begin
         rdata <= '0;
         err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a
// byte-level array model of the memory and its error rules.
module tb_data_mem_responder;

   localparam int WIDTH   = 32;
   localparam int DEPTH   = 256;
   localparam int LATENCY = 2;
   localparam int BOUND   = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ready;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [DEPTH];
   bit   [3:0]  known [DEPTH];

   data_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .ready (ready),
      .ack   (ack),
      .rdata (rdata),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected response of one transaction; updates the model for stores.
   function automatic void model_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] b, output logic [31:0] r,
                                    output bit e, output bit r_known);
      longint unsigned widx = longint'(a) / 4;
      e       = (a % 4 != 0) || (widx >= DEPTH);
      r       = '0;
      r_known = 1'b1;
      if (!e) begin
         if (w) begin
            for (int i = 0; i < 4; i++) begin
               if (b[i]) begin
                  model[int'(widx)][8*i +: 8] = d[8*i +: 8];
                  known[int'(widx)][i]        = 1'b1;
               end
            end
         end else begin
            r       = model[int'(widx)];
            r_known = &known[int'(widx)];
         end
      end
   endfunction

   task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input string tag);
      logic [31:0] er;
      bit          ee, ek;
      int          n;
      model_op(w, a, d, b, er, ee, ek);
      @(negedge clk);
      n = 0;
      while (!ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready_before"}, ready, 1'b1);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(negedge clk);
      // Scramble the request fields after acceptance; the captured copy must win.
      req = 1'b0; addr = $urandom; wdata = $urandom; be = 4'($urandom); we = ~w;
      n = 1;
      check({tag, "_busy_ready"}, ready, 1'b0);
      while (!ack && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ack_cycle"}, n, LATENCY + 1);
      check({tag, "_err"}, err, ee);
      check({tag, "_resp_ready"}, ready, 1'b0);
      if (ek) check({tag, "_rdata"}, rdata, er);
      @(negedge clk);
      check({tag, "_ack_once"}, ack, 1'b0);
      check({tag, "_ready_after"}, ready, 1'b1);
   endtask

   task automatic back_to_back();
      logic [31:0] bb_addr [3];
      int acc = 0, acks = 0, cyc = 0, last = -1, rdy = 0;
      bb_addr[0] = 32'h100; bb_addr[1] = 32'h104; bb_addr[2] = 32'h108;
      for (int i = 0; i < 3; i++) do_op(1'b1, bb_addr[i], $urandom, 4'hF, "bb_fill");
      @(negedge clk);
      req = 1'b1; we = 1'b0; be = '0; wdata = '0;
      while (acks < 3 && cyc < 100) begin
         if (ready) begin
            rdy++;
            if (acc < 3) begin
               addr = bb_addr[acc];
               acc++;
            end
         end else if (acc == 3) begin
            req = 1'b0;
         end
         if (ack) begin
            check("bb_rdata", rdata, model[int'(bb_addr[acks] >> 2)]);
            check("bb_err", err, 1'b0);
            if (last >= 0) check("bb_spacing", cyc - last, LATENCY + 2);
            last = cyc;
            acks++;
         end
         @(negedge clk);
         cyc++;
      end
      req = 1'b0;
      check("bb_acks", acks, 3);
      check("bb_accepts", acc, 3);
      check("bb_ready_cycles", rdy, 3);
   endtask

   initial begin
      logic [31:0] a;
      int          kind;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_ack", ack, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", ready, 1'b1);
      check("idle_ack", ack, 1'b0);
      check("idle_rdata", rdata, 32'h0);
      check("idle_err", err, 1'b0);

      do_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
      do_op(1'b0, 32'h10, 32'h0, 4'h0, "ld10");
      do_op(1'b1, 32'h20, 32'h11223344, 4'hF, "st20");
      do_op(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "st20_be");
      do_op(1'b0, 32'h20, 32'h0, 4'h0, "ld20_merge");
      check("merge_model", model[8], 32'h11BB33DD);

      do_op(1'b1, 32'h0, 32'h5A5A1234, 4'hF, "st0");
      do_op(1'b0, 32'h13, 32'h0, 4'h0, "ld_misalign");
      do_op(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, "st_oob");
      do_op(1'b1, 32'h1, 32'hFFFFFFFF, 4'hF, "st_misalign");
      do_op(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, "st_be0");
      do_op(1'b0, 32'h0, 32'h0, 4'h0, "ld0_unchanged");

      back_to_back();

      do_op(1'b1, 32'h40, 32'h0, 4'hF, "st40_zero");
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; be = 4'hF;
      @(negedge clk);
      req = 1'b0;
      check("mid_busy_ready", ready, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", ready, 1'b1);
      check("mid_rst_ack", ack, 1'b0);
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      do_op(1'b0, 32'h40, 32'h0, 4'h0, "ld40_after_rst");

      for (int i = 0; i < 32; i++) do_op(1'b1, 32'(4 * i), $urandom, 4'hF, "fill");
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0)      a = 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
         else if (kind == 1) a = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
         else if (kind == 2) a = $urandom | 32'h8000_0000;
         else                a = 32'(4 * $urandom_range(0, 31));
         do_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data memory that acts as the responder on the CPU load/store request/acknowledge interface.
- Accepts one request at a time from the datapath initiator and holds it for a fixed, parameterized access latency.
- Then commits the write or reads the word, and returns a one-cycle acknowledge with read data and error status.
- Used as the data-memory model behind the multi-cycle and pipelined CPU variants.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8; byte lanes = WIDTH/8.
- DEPTH, 256, number of words in the memory array.
- LATENCY, 2, cycles from request acceptance to acknowledge; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- req  input  1  initiator request valid; held until sampled with ready=1.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address; word index = addr[31:2].
- wdata  input  WIDTH  store data.
- be  input  WIDTH/8  byte enables for stores; ignored for loads.
- ready  output  1  responder idle; a request is accepted at a rising edge where req=1 and ready=1.
- ack  output  1  one-cycle response strobe.
- rdata  output  WIDTH  load data; valid only while ack=1.
- err  output  1  request faulted; valid only while ack=1.

Behaviour:
- Reset: ready=1, ack=0, rdata=0, err=0, state=IDLE, counter=0. Memory contents are not reset.
- FSM states: IDLE, BUSY, RESP. All outputs are registered or decoded from state only (Moore); there are no combinational paths from inputs to outputs.
- IDLE: ready=1.
  - If req=1 at an edge, capture we, addr, wdata and be, load counter=LATENCY-1, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: ready=0.
  - If counter!=0, decrement it.
  - If counter==0, perform the access at this edge and go to RESP.
- RESP: ack=1 for exactly one cycle, ready=0; then go to IDLE.
- Timing: request accepted at edge E0 -> ack high in the cycle following edge E0+LATENCY -> ready high again after edge E0+LATENCY+1. Back-to-back requests therefore occur every LATENCY+2 cycles.
- Access rules:
  - Error condition: addr[1:0]!=0 or word index >= DEPTH. Result: err=1, rdata=0, memory unchanged.
  - Load: rdata = mem[index], err=0.
  - Store: each byte lane i with be[i]=1 is written; lanes with be[i]=0 are preserved; rdata=0, err=0.
  - Store with be=0: no change, err=0 (legal no-op).
- Captured request fields are frozen after acceptance; changes on req/addr/wdata while busy have no effect.
- req=0 while busy has no effect; there is no abort.
- req held high into the RESP cycle is not accepted, because ready=0. It is accepted in the next IDLE cycle.
- Reset mid-operation (BUSY or RESP): immediate return to reset values. A store not yet committed at the BUSY->RESP edge is discarded. A store already committed stays in memory.
- LATENCY=1: BUSY lasts one cycle (counter loads 0).

Decomposition:
- Shared package: state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the counter width constant (4).
- Sub-module: the captured-request holding register is an instance of the team's generic parameterized register (data, clk, rst, load enable, q), loaded on acceptance.
- Memory array and FSM live in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release -> ready=1, ack=0, rdata=0, err=0.
- Store then load, LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF -> ack exactly 2 cycles after acceptance, err=0. Then load addr=0x10 -> rdata=0xDEADBEEF with ack.
- Byte-enable merge: store 0x11223344 to addr=0x20 with be=4'hF, then store 0xAABBCCDD with be=4'b0101, then load addr=0x20 -> rdata=0x11BB33DD.
- Errors: load addr=0x13 -> ack with err=1, rdata=0. Store to addr=4*DEPTH -> err=1. A follow-up load of addr=0 shows its prior contents unchanged.
- Back-to-back: req held high continuously across 3 loads -> acks spaced LATENCY+2 cycles apart. ready=0 while BUSY/RESP, and no request is lost or duplicated.
- Reset mid-store: accept store 0xCAFEF00D to addr=0x40 (previously 0x0) and assert rst during BUSY -> outputs return to reset values immediately. A subsequent load of addr=0x40 returns 0x0.
